// File: rtl/uart_loopback_top.sv
// 8N1 UART echo: every byte received on uart_rxd is retransmitted on uart_txd,
// with a one-byte holding buffer covering back-to-back arrivals while TX is busy.
module uart_loopback_top #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic uart_rxd,
    output logic uart_txd
);
    localparam int               BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int               CNT_W    = $clog2(BPS_CNT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'(BPS_CNT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic [2:0]       rxd_sync_q;
    logic             rx_in;
    logic             rx_fall;
    state_e           rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic [7:0]       rx_data_q;
    logic             rx_done_q;

    state_e           tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_data_q;
    logic             txd_q;
    logic [7:0]       buf_q;
    logic             buf_full_q;

    logic             tx_end;
    logic             tx_free;
    logic             launch;
    logic [7:0]       launch_byte;

    // [0]/[1] form the synchroniser, [2] is the previous synced level for edge detect
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) rxd_sync_q <= 3'b111;
        else         rxd_sync_q <= {rxd_sync_q[1:0], uart_rxd};
    end

    assign rx_in   = rxd_sync_q[1];
    assign rx_fall = rxd_sync_q[2] & ~rxd_sync_q[1];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= S_START;
                        rx_cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == BIT_MID && rx_in) begin
                        rx_state_q <= S_IDLE;
                        rx_cnt_q   <= '0;
                    end else if (rx_cnt_q == BIT_LAST) begin
                        rx_state_q <= S_DATA;
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == BIT_MID) rx_shift_q <= {rx_in, rx_shift_q[7:1]};
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop so the next start edge is seen without delay
                    if (rx_cnt_q == BIT_MID) begin
                        rx_state_q <= S_IDLE;
                        rx_cnt_q   <= '0;
                        if (rx_in) begin
                            rx_done_q <= 1'b1;
                            rx_data_q <= rx_shift_q;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_end      = (tx_state_q == S_STOP) && (tx_cnt_q == BIT_LAST);
    assign tx_free     = (tx_state_q == S_IDLE) || tx_end;
    assign launch      = tx_free && (buf_full_q || rx_done_q);
    assign launch_byte = buf_full_q ? buf_q : rx_data_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
            txd_q      <= 1'b1;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            // Buffered byte wins a free TX slot; a coincident new byte takes its place
            if (tx_free && buf_full_q) begin
                if (rx_done_q) buf_q      <= rx_data_q;
                else           buf_full_q <= 1'b0;
            end else if (rx_done_q && !tx_free && !buf_full_q) begin
                buf_q      <= rx_data_q;
                buf_full_q <= 1'b1;
            end

            if (launch) begin
                tx_state_q <= S_START;
                tx_cnt_q   <= '0;
                tx_bit_q   <= '0;
                tx_data_q  <= launch_byte;
                txd_q      <= 1'b0;
            end else begin
                case (tx_state_q)
                    S_IDLE: txd_q <= 1'b1;
                    S_START: begin
                        if (tx_cnt_q == BIT_LAST) begin
                            tx_state_q <= S_DATA;
                            tx_cnt_q   <= '0;
                            txd_q      <= tx_data_q[0];
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CNT_ONE;
                        end
                    end
                    S_DATA: begin
                        if (tx_cnt_q == BIT_LAST) begin
                            tx_cnt_q <= '0;
                            if (tx_bit_q == 3'd7) begin
                                tx_state_q <= S_STOP;
                                txd_q      <= 1'b1;
                            end else begin
                                tx_bit_q <= tx_bit_q + 3'd1;
                                txd_q    <= tx_data_q[tx_bit_q + 3'd1];
                            end
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CNT_ONE;
                        end
                    end
                    S_STOP: begin
                        if (tx_cnt_q == BIT_LAST) begin
                            tx_state_q <= S_IDLE;
                            tx_cnt_q   <= '0;
                            txd_q      <= 1'b1;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        tx_state_q <= S_IDLE;
                        txd_q      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_loopback_top.sv
// Bench for uart_loopback_top: directed and random frames on uart_rxd, with a
// frame decoder on uart_txd compared against a queue of bytes that must echo.
`timescale 1ns/1ps
module tb_uart_loopback_top;
    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 1_000_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int LAT_NOM  = (BPS * 19) / 2;
    localparam int LAT_MIN  = LAT_NOM - 2;
    localparam int LAT_MAX  = LAT_NOM + 9;

    logic sys_clk;
    logic sys_rst;
    logic uart_rxd;
    logic uart_txd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int   n_pushed    = 0;
    int   frames_seen = 0;
    int   starts_seen = 0;
    logic in_frame    = 1'b0;
    logic mon_en      = 1'b0;
    int   last_start_cyc = 0;
    int   rx_fall_cyc    = 0;

    logic [9:0] mon_bits;
    int         mon_dev;
    logic [7:0] mon_exp;

    uart_loopback_top #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd)
    );

    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Drives one frame starting on a falling clock edge; returns on a falling edge
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        rx_fall_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (BPS) @(negedge sys_clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        n_pushed++;
        send_frame(b, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 40 * BPS) begin
            @(negedge sys_clk);
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
        repeat (BPS) @(negedge sys_clk);
    endtask

    // Frame decoder: every bit level must hold for exactly BPS clocks
    always begin
        @(negedge sys_clk);
        if (mon_en && uart_txd === 1'b0) begin
            in_frame       = 1'b1;
            starts_seen++;
            last_start_cyc = cyc;
            mon_dev        = 0;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < BPS; c++) begin
                    if (!(b == 0 && c == 0)) @(negedge sys_clk);
                    if (c == 0) mon_bits[b] = uart_txd;
                    else if (uart_txd !== mon_bits[b]) mon_dev++;
                end
            end
            frames_seen++;
            chk("tx_bit_width", mon_dev, 0);
            chk("tx_stop_bit", int'(mon_bits[9]), 1);
            chk("tx_frame_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("tx_echo_data", int'(mon_bits[8:1]), int'(mon_exp));
            end
            in_frame = 1'b0;
        end
    end

    initial begin
        logic [7:0] b;
        int bad;
        int s0;
        int lat;
        logic got_fall;

        sys_rst  = 1'b1;
        uart_rxd = 1'b1;
        mon_en   = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) bad++;
        end
        chk("reset_txd_high", bad, 0);
        sys_rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) bad++;
        end
        chk("idle_after_reset", bad, 0);

        send_byte(8'h55);
        drain();
        lat = last_start_cyc - rx_fall_cyc;
        chk("echo_latency_in_window", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        chk("echo_count_0x55", frames_seen, 1);

        send_byte(8'h00);
        send_byte(8'hFF);
        drain();
        chk("echo_count_b2b", frames_seen, 3);

        s0 = starts_seen;
        uart_rxd = 1'b0;
        repeat (BPS * 2 / 5) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (BPS / 5) @(negedge sys_clk);
        uart_rxd = 1'b0;
        repeat (BPS / 5) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (12 * BPS) @(negedge sys_clk);
        chk("false_start_quiet", starts_seen - s0, 0);
        send_byte(8'hA3);
        drain();

        s0 = starts_seen;
        send_frame(8'h3C, 1'b0);
        repeat (12 * BPS) @(negedge sys_clk);
        chk("framing_error_quiet", starts_seen - s0, 0);
        send_byte(8'h81);
        drain();

        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                send_frame(b, 1'b0);
                repeat (BPS + $urandom_range(0, 20)) @(negedge sys_clk);
            end else begin
                send_byte(b);
                if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 60)) @(negedge sys_clk);
            end
        end
        drain();
        chk("echo_count_random", frames_seen, n_pushed);

        mon_en = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
        join_none
        got_fall = 1'b0;
        for (int i = 0; i < 20 * BPS && !got_fall; i++) begin
            @(negedge sys_clk);
            if (uart_txd === 1'b0) got_fall = 1'b1;
        end
        chk("rst_test_tx_started", int'(got_fall), 1);
        repeat (4 * BPS + BPS / 2) @(negedge sys_clk);
        chk("rst_test_data3_low", int'(uart_txd), 0);
        #3 sys_rst = 1'b1;
        #1 chk("rst_txd_immediate", int'(uart_txd), 1);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        bad = 0;
        repeat (12 * BPS) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) bad++;
        end
        chk("rst_no_resume", bad, 0);

        mon_en = 1'b1;
        s0 = frames_seen;
        send_byte(8'h5A);
        drain();
        chk("echo_after_reset", frames_seen - s0, 1);
        chk("total_frames", frames_seen, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
